// File: rtl/majority_vote_filter_if.sv
// Stream interface for majority_vote_filter: sample input side, result
// output side and the window-flush control, grouped so the filter and its
// driver/consumer share a single bundle.
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high; valid, once raised, holds its data stable until that edge.
interface majority_vote_filter_if #(
    parameter int N = 4
);
    localparam int POP_W = $clog2(N + 1);

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     I;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             out_maj;
    logic             out_spatial;
    logic             out_tie;
    logic [POP_W-1:0] out_pop;
    logic [7:0]       tie_cnt;

    // Producer of samples and consumer of results.
    modport master (
        output in_valid, I, flush, out_ready,
        input  in_ready, out_valid, out_maj, out_spatial, out_tie, out_pop, tie_cnt
    );

    // The filter itself.
    modport slave (
        input  in_valid, I, flush, out_ready,
        output in_ready, out_valid, out_maj, out_spatial, out_tie, out_pop, tie_cnt
    );
endinterface

// File: rtl/majority_vote_filter.sv
// majority_vote_filter: spatial majority across N vote inputs per sample,
// followed by a temporal majority over the last W accepted samples.
// One registered output stage; in_ready = !out_valid || out_ready.
// Optional feature macro: MAJ_TIE_COUNT_EN (saturating 8-bit tie counter on
// tie_cnt; when undefined tie_cnt is tied to zero and no register is built).
module majority_vote_filter #(
    parameter int N       = 4,
    parameter int W       = 3,
    parameter bit TIE_VAL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    majority_vote_filter_if.slave bus
);
    localparam int POP_W  = $clog2(N + 1);
    localparam int CMP_W  = POP_W + 1;
    localparam int WC_W   = $clog2(W + 1);
    localparam int WCMP_W = WC_W + 1;

    generate
        if (N < 2) begin : g_bad_n
            $error("majority_vote_filter: N must be >= 2");
        end
        if ((W < 1) || ((W % 2) == 0)) begin : g_bad_w
            $error("majority_vote_filter: W must be odd and >= 1");
        end
    endgenerate

    logic             out_valid_q;
    logic             out_maj_q;
    logic             out_spatial_q;
    logic             out_tie_q;
    logic [POP_W-1:0] out_pop_q;
    logic [W-1:0]     hist_q, hist_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;

    logic             accept;
    logic [POP_W-1:0] pop_c;
    logic [CMP_W-1:0] pop2_c;
    logic             tie_c;
    logic             spatial_c;
    logic [W-1:0]     hist_base;
    logic [WC_W-1:0]  wcnt_base;
    logic [W-1:0]     hist_shift;
    logic [WC_W-1:0]  wcnt_shift;
    logic             maj_c;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Spatial vote: popcount, then compare 2*pop against N at a width wide
    // enough to hold 2*N so nothing is truncated.
    always_comb begin
        pop_c = '0;
        for (int k = 0; k < N; k++) begin
            pop_c = pop_c + POP_W'(bus.I[k]);
        end
        pop2_c    = {pop_c, 1'b0};
        tie_c     = (pop2_c == CMP_W'(N));
        spatial_c = tie_c ? TIE_VAL : (pop2_c > CMP_W'(N));
    end

    // Temporal window: flush clears the history before any shift in the same
    // cycle, so flush+accept leaves only the new vote in the window.
    always_comb begin
        hist_base  = bus.flush ? '0 : hist_q;
        wcnt_base  = bus.flush ? '0 : wcnt_q;
        hist_shift = (hist_base << 1) | W'(spatial_c);
        wcnt_shift = wcnt_base + WC_W'(spatial_c) - WC_W'(hist_base[W-1]);
        maj_c      = ({wcnt_shift, 1'b0} > WCMP_W'(W));
        hist_d     = accept ? hist_shift : hist_base;
        wcnt_d     = accept ? wcnt_shift : wcnt_base;
    end

    // History shift register and running count of ones in it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            wcnt_q <= '0;
        end else begin
            hist_q <= hist_d;
            wcnt_q <= wcnt_d;
        end
    end

    // Output stage: load on accept, drop valid when drained without refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_maj_q     <= 1'b0;
            out_spatial_q <= 1'b0;
            out_tie_q     <= 1'b0;
            out_pop_q     <= '0;
        end else if (accept) begin
            out_valid_q   <= 1'b1;
            out_maj_q     <= maj_c;
            out_spatial_q <= spatial_c;
            out_tie_q     <= tie_c;
            out_pop_q     <= pop_c;
        end else if (bus.out_ready) begin
            out_valid_q   <= 1'b0;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_maj     = out_maj_q;
    assign bus.out_spatial = out_spatial_q;
    assign bus.out_tie     = out_tie_q;
    assign bus.out_pop     = out_pop_q;

`ifdef MAJ_TIE_COUNT_EN
    logic [7:0] tie_cnt_q;

    // Count accepted tie samples, saturating at 255; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tie_cnt_q <= 8'd0;
        end else if (accept && tie_c && (tie_cnt_q != 8'd255)) begin
            tie_cnt_q <= tie_cnt_q + 8'd1;
        end
    end

    assign bus.tie_cnt = tie_cnt_q;
`else
    assign bus.tie_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_majority_vote_filter.sv
// Bench for majority_vote_filter (N=4, W=3, TIE_VAL=0): directed sequences
// from the test plan plus randomized traffic, checked by a scoreboard fed
// from a window-queue reference model.
module tb_majority_vote_filter;
    localparam int N       = 4;
    localparam int W       = 3;
    localparam bit TIE_VAL = 1'b0;
    localparam int PW      = $clog2(N + 1);
    localparam int EXP_W   = 8 + PW + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    majority_vote_filter_if #(.N(N)) bus ();

    majority_vote_filter #(.N(N), .W(W), .TIE_VAL(TIE_VAL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock
    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_pass = 0;
    logic [EXP_W-1:0] exp_q[$];
    int               win[$];
    int               ties;
    logic             exp_ov;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        win.delete();
        for (int i = 0; i < W; i++) win.push_back(0);
        ties   = 0;
        exp_ov = 1'b0;
    endfunction

    // Reference model: evaluated mid-cycle for the edge that follows.
    function automatic void model_step();
        logic       exp_rdy;
        logic       acc;
        int         pop;
        int         ones;
        logic       tie;
        logic       sp;
        logic       maj;
        logic [7:0] tc;
        exp_rdy = !exp_ov || bus.out_ready;
        check("in_ready", bus.in_ready, exp_rdy);
        check("out_valid", bus.out_valid, exp_ov);
        acc = bus.in_valid && exp_rdy;
        if (bus.flush) begin
            win.delete();
            for (int i = 0; i < W; i++) win.push_back(0);
        end
        if (acc) begin
            pop = $countones(bus.I);
            tie = (2 * pop == N);
            sp  = tie ? TIE_VAL : (2 * pop > N);
            win.push_back(int'(sp));
            void'(win.pop_front());
            ones = 0;
            foreach (win[k]) ones += win[k];
            maj = (2 * ones > W);
            if (tie) ties++;
`ifdef MAJ_TIE_COUNT_EN
            tc = (ties > 255) ? 8'd255 : 8'(ties);
`else
            tc = 8'd0;
`endif
            exp_q.push_back({tc, pop[PW-1:0], tie, sp, maj});
        end
        if (acc) exp_ov = 1'b1;
        else if (bus.out_ready) exp_ov = 1'b0;
    endfunction

    // Model process: clears on reset, otherwise predicts the coming edge.
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Monitor: compare displayed result against the oldest expectation,
    // retire it when the consumer takes it.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", bus.out_valid, 1'b0);
            end else begin
                check("out_maj", bus.out_maj, exp_q[0][0]);
                check("out_spatial", bus.out_spatial, exp_q[0][1]);
                check("out_tie", bus.out_tie, exp_q[0][2]);
                check("out_pop", bus.out_pop, exp_q[0][PW+2:3]);
                check("tie_cnt", bus.tie_cnt, exp_q[0][EXP_W-1:PW+3]);
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [N-1:0] i, input logic f, input logic r);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.I         = i;
        bus.flush     = f;
        bus.out_ready = r;
    endtask

    task automatic check_reset_state();
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_maj", bus.out_maj, 1'b0);
        check("rst_out_spatial", bus.out_spatial, 1'b0);
        check("rst_out_tie", bus.out_tie, 1'b0);
        check("rst_out_pop", bus.out_pop, 0);
        check("rst_tie_cnt", bus.tie_cnt, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Stimulus
    initial begin
        bus.in_valid  = 1'b0;
        bus.I         = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        model_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back 0111 samples: out_maj 0,1,1.
        repeat (3) drive(1'b1, 4'b0111, 1'b0, 1'b1);
        drive(1'b0, 4'b0000, 1'b0, 1'b1);

        // Exact tie.
        drive(1'b1, 4'b0011, 1'b0, 1'b1);
        drive(1'b0, 4'b0000, 1'b0, 1'b1);

        // Backpressure: result held, new samples ignored, then accepted.
        drive(1'b1, 4'b1000, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 4'b1111, 1'b0, 1'b0);
        drive(1'b1, 4'b1111, 1'b0, 1'b1);
        drive(1'b0, 4'b0000, 1'b0, 1'b1);

        // Full window, then flush with accept, then flush alone.
        repeat (3) drive(1'b1, 4'b1111, 1'b0, 1'b1);
        drive(1'b1, 4'b1111, 1'b1, 1'b1);
        drive(1'b0, 4'b0000, 1'b0, 1'b1);
        drive(1'b0, 4'b0000, 1'b1, 1'b1);
        drive(1'b1, 4'b0000, 1'b0, 1'b1);
        drive(1'b0, 4'b0000, 1'b0, 1'b1);

        // Tie counter saturation.
        repeat (300) drive(1'b1, 4'b0101, 1'b0, 1'b1);
        drive(1'b0, 4'b0000, 1'b0, 1'b1);
        drive(1'b0, 4'b0000, 1'b0, 1'b1);
`ifdef MAJ_TIE_COUNT_EN
        check("tie_cnt_sat", bus.tie_cnt, (ties > 255) ? 255 : ties);
`else
        check("tie_cnt_off", bus.tie_cnt, 0);
`endif

        // Randomized traffic with a reset in the middle.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
        end

        // Drain.
        repeat (4) drive(1'b0, 4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
